// File: rtl/video_pattern_source.sv
// video_pattern_source
// AXI4-Stream test-pattern generator for bring-up of the video output path.
// Produces 32-bit {8'h00, B, G, R} pixels with tuser on the first pixel of a
// frame and tlast on the last pixel of each line. Geometry, pattern and colour
// are captured once per frame so a frame is always self-consistent, and the
// stream stalls cleanly under tready backpressure.
module video_pattern_source #(
  parameter int MAXWIDTH  = 1280,
  parameter int MAXHEIGHT = 1024
) (
  input  logic        m_axis_vid_aclk,
  input  logic        aresetn,
  output logic [31:0] m_axis_vid_tdata,
  output logic        m_axis_vid_tvalid,
  input  logic        m_axis_vid_tready,
  output logic        m_axis_vid_tlast,
  output logic        m_axis_vid_tuser,
  input  logic        enable,
  input  logic [11:0] cfg_width,
  input  logic [11:0] cfg_height,
  input  logic [1:0]  cfg_pattern,
  input  logic [23:0] cfg_color,
  output logic [15:0] frame_count,
  output logic        frame_done
);

  localparam logic [11:0] MAX_W = 12'(MAXWIDTH);
  localparam logic [11:0] MAX_H = 12'(MAXHEIGHT);

  localparam logic [1:0] PAT_SOLID    = 2'd0;
  localparam logic [1:0] PAT_GRADIENT = 2'd1;
  localparam logic [1:0] PAT_BARS     = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Force a frame dimension into 1..max so the x/y wrap compares are always valid.
  function automatic logic [11:0] clamp_dim(input logic [11:0] val,
                                            input logic [11:0] max_val);
    logic [11:0] res;
    if (val == 12'd0) begin
      res = 12'd1;
    end else if (val > max_val) begin
      res = max_val;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Pixel colour {B, G, R} for one beat. Only the low coordinate bits matter:
  // gradient uses x[7:0]/y[7:0], bars use x[9:7], checker uses bit 4.
  function automatic logic [23:0] pattern_pixel(input logic [1:0]  pattern,
                                                input logic [23:0] color,
                                                input logic [7:0]  frame_lsb,
                                                input logic [9:0]  x_lsb,
                                                input logic [7:0]  y_lsb);
    logic [2:0]  bar;
    logic        carry4;
    logic        sum4;
    logic [23:0] px;
    // Bars run white..black left to right, hence the inversion of x[9:7].
    bar = ~x_lsb[9:7];
    // Bit 4 of (x + F) mod 4096 depends only on bits 4:0 of both operands:
    // the bit itself plus the carry out of the low nibble.
    carry4 = ({1'b0, x_lsb[3:0]} + {1'b0, frame_lsb[3:0]}) > 5'd15;
    sum4   = x_lsb[4] ^ frame_lsb[4] ^ carry4;
    case (pattern)
      PAT_SOLID:    px = color;
      PAT_GRADIENT: px = {frame_lsb, y_lsb, x_lsb[7:0]};
      PAT_BARS:     px = {{8{bar[0]}}, {8{bar[2]}}, {8{bar[1]}}};
      default:      px = (sum4 ^ y_lsb[4]) ? color : 24'h000000;
    endcase
    return px;
  endfunction

  state_t      state_q,       state_d;
  logic [11:0] width_q,       width_d;
  logic [11:0] height_q,      height_d;
  logic [1:0]  pattern_q,     pattern_d;
  logic [23:0] color_q,       color_d;
  logic [7:0]  frame_lsb_q,   frame_lsb_d;
  logic [11:0] x_q,           x_d;
  logic [11:0] y_q,           y_d;
  logic [31:0] tdata_q,       tdata_d;
  logic        tvalid_q,      tvalid_d;
  logic        tlast_q,       tlast_d;
  logic        tuser_q,       tuser_d;
  logic        frame_done_q,  frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        handshake;
  logic        line_end;
  logic        last_beat;
  logic        present;
  logic [11:0] beat_x;
  logic [11:0] beat_y;

  assign handshake = tvalid_q & m_axis_vid_tready;
  assign line_end  = (x_q == width_q - 12'd1);
  assign last_beat = line_end & (y_q == height_q - 12'd1);

  // Next-state, coordinate advance and next-beat generation. The beat being
  // presented next is computed here and registered, so tready never reaches
  // an output combinationally.
  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    height_d      = height_q;
    pattern_d     = pattern_q;
    color_d       = color_q;
    frame_lsb_d   = frame_lsb_q;
    x_d           = x_q;
    y_d           = y_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    present       = 1'b0;
    beat_x        = x_q;
    beat_y        = y_q;

    case (state_q)
      ST_IDLE: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
        if (enable) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Capture the frame's configuration and present pixel (0,0) built
        // from the freshly captured values.
        width_d     = clamp_dim(cfg_width, MAX_W);
        height_d    = clamp_dim(cfg_height, MAX_H);
        pattern_d   = cfg_pattern;
        color_d     = cfg_color;
        frame_lsb_d = frame_count_q[7:0];
        x_d         = 12'd0;
        y_d         = 12'd0;
        beat_x      = 12'd0;
        beat_y      = 12'd0;
        present     = 1'b1;
        state_d     = ST_STREAM;
      end

      ST_STREAM: begin
        // Without a handshake every output register simply holds.
        if (handshake) begin
          if (last_beat) begin
            state_d       = ST_DONE;
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            tuser_d       = 1'b0;
            tdata_d       = 32'h0000_0000;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            if (line_end) begin
              beat_x = 12'd0;
              beat_y = y_q + 12'd1;
            end else begin
              beat_x = x_q + 12'd1;
            end
            x_d     = beat_x;
            y_d     = beat_y;
            present = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // enable is only looked at between frames, never inside one.
        state_d = enable ? ST_LOAD : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The *_d config values equal the captured ones in STREAM and the new
    // ones in LOAD, so one expression covers both cases.
    if (present) begin
      tvalid_d = 1'b1;
      tdata_d  = {8'h00, pattern_pixel(pattern_d, color_d, frame_lsb_d,
                                       beat_x[9:0], beat_y[7:0])};
      tlast_d  = (beat_x == width_d - 12'd1);
      tuser_d  = (beat_x == 12'd0) && (beat_y == 12'd0);
    end
  end

  // State and output registers; reset drops every output to zero at once.
  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      width_q       <= 12'd1;
      height_q      <= 12'd1;
      pattern_q     <= 2'd0;
      color_q       <= 24'h000000;
      frame_lsb_q   <= 8'h00;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      tdata_q       <= 32'h0000_0000;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      height_q      <= height_d;
      pattern_q     <= pattern_d;
      color_q       <= color_d;
      frame_lsb_q   <= frame_lsb_d;
      x_q           <= x_d;
      y_q           <= y_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_axis_vid_tdata  = tdata_q;
  assign m_axis_vid_tvalid = tvalid_q;
  assign m_axis_vid_tlast  = tlast_q;
  assign m_axis_vid_tuser  = tuser_q;
  assign frame_done        = frame_done_q;
  assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// tb_video_pattern_source
// Directed bench for video_pattern_source: solid frame, backpressure, colour
// bars, gradient over two frames, mid-frame enable/cfg changes, mid-frame
// reset and width/height clamping. Outputs are sampled on the falling edge.
module tb_video_pattern_source;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic        enable;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [1:0]  cfg_pattern;
  logic [23:0] cfg_color;
  logic [15:0] frame_count;
  logic        frame_done;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [31:0] cap_data[$];
  logic        cap_last[$];
  logic        cap_user[$];
  int          cap_it[$];

  always #5 clk = ~clk;

  video_pattern_source #(
    .MAXWIDTH (1280),
    .MAXHEIGHT(1024)
  ) dut (
    .m_axis_vid_aclk  (clk),
    .aresetn          (aresetn),
    .m_axis_vid_tdata (tdata),
    .m_axis_vid_tvalid(tvalid),
    .m_axis_vid_tready(tready),
    .m_axis_vid_tlast (tlast),
    .m_axis_vid_tuser (tuser),
    .enable           (enable),
    .cfg_width        (cfg_width),
    .cfg_height       (cfg_height),
    .cfg_pattern      (cfg_pattern),
    .cfg_color        (cfg_color),
    .frame_count      (frame_count),
    .frame_done       (frame_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [11:0] w, input logic [11:0] h,
                         input logic [1:0] p, input logic [23:0] c);
    cfg_width   = w;
    cfg_height  = h;
    cfg_pattern = p;
    cfg_color   = c;
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_last.delete();
    cap_user.delete();
    cap_it.delete();
  endtask

  // Collect n accepted beats (appended to the capture queues), checking that
  // a stalled beat is held unchanged. Bounded by budget falling edges.
  task automatic capture(input string tag, input int n, input bit rnd, input int budget);
    int          got;
    bit          stall;
    logic [31:0] pd;
    logic        pl;
    logic        pu;
    got   = 0;
    stall = 1'b0;
    pd    = '0;
    pl    = 1'b0;
    pu    = 1'b0;
    for (int it = 0; it < budget && got < n; it++) begin
      @(negedge clk);
      if (stall) begin
        check_eq({tag, "_hold_valid"}, tvalid, 1);
        check_eq({tag, "_hold_beat"}, {tuser, tlast, tdata}, {pu, pl, pd});
      end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid && tready) begin
        cap_data.push_back(tdata);
        cap_last.push_back(tlast);
        cap_user.push_back(tuser);
        cap_it.push_back(it);
        got++;
      end
      stall = tvalid && !tready;
      pd    = tdata;
      pl    = tlast;
      pu    = tuser;
    end
    if (got != n) check_eq({tag, "_beat_count"}, got, n);
    $display("frame %s: %0d beats accepted", tag, got);
  endtask

  // Compare the 4x2 solid frame: tuser on beat 0, tlast on beats 3 and 7.
  task automatic check_solid_4x2(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (i < cap_data.size()) begin
        check_eq($sformatf("%s_beat%0d", tag, i),
                 {cap_user[i], cap_last[i], cap_data[i]},
                 {(i == 0), (i == 3 || i == 7), 32'h0033_2211});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    tready  = 1'b1;
    enable  = 1'b0;
    set_cfg(12'd4, 12'd2, 2'd0, 24'h332211);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_tdata", tdata, 0);
    check_eq("rst_tvalid", tvalid, 0);
    check_eq("rst_tlast", tlast, 0);
    check_eq("rst_tuser", tuser, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_frame_count", frame_count, 0);
    aresetn = 1'b1;
    @(negedge clk);

    // Solid 4x2, no backpressure, enable pulsed
    enable = 1'b1;
    @(negedge clk);
    check_eq("s1_load_tvalid", tvalid, 0);
    enable = 1'b0;
    clear_cap();
    capture("s1", 8, 1'b0, 50);
    if (cap_it.size() > 0) check_eq("s1_start_latency", cap_it[0], 0);
    check_solid_4x2("s1");
    @(negedge clk);
    check_eq("s1_done_pulse", {frame_done, tvalid}, 2'b10);
    check_eq("s1_frame_count", frame_count, 1);
    @(negedge clk);
    check_eq("s1_done_clear", {frame_done, tvalid}, 2'b00);
    repeat (3) @(negedge clk);
    check_eq("s1_idle_tvalid", tvalid, 0);

    // Same frame under random backpressure
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    clear_cap();
    capture("s2", 8, 1'b1, 300);
    tready = 1'b1;
    check_solid_4x2("s2");
    @(negedge clk);
    check_eq("s2_done_pulse", frame_done, 1);
    check_eq("s2_frame_count", frame_count, 2);

    // Colour bars, 1024x1
    set_cfg(12'd1024, 12'd1, 2'd2, 24'h000000);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    clear_cap();
    capture("s3", 1024, 1'b0, 1100);
    if (cap_data.size() == 1024) begin
      check_eq("s3_bar_x0", cap_data[0], 32'h00FF_FFFF);
      check_eq("s3_bar_x128", cap_data[128], 32'h0000_FFFF);
      check_eq("s3_bar_x640", cap_data[640], 32'h0000_00FF);
      check_eq("s3_bar_x1023", cap_data[1023], 32'h0000_0000);
      check_eq("s3_tlast_1022", cap_last[1022], 0);
      check_eq("s3_tlast_1023", cap_last[1023], 1);
    end
    @(negedge clk);
    check_eq("s3_frame_count", frame_count, 3);

    // Gradient, 300x2, two back-to-back frames from a fresh frame count
    aresetn = 1'b0;
    @(negedge clk);
    check_eq("s4_rst_frame_count", frame_count, 0);
    aresetn = 1'b1;
    set_cfg(12'd300, 12'd2, 2'd1, 24'h000000);
    enable = 1'b1;
    clear_cap();
    capture("s4", 1200, 1'b0, 1400);
    enable = 1'b0;
    if (cap_data.size() == 1200) begin
      check_eq("s4_f0_x257_y1", cap_data[557], 32'h0000_0101);
      check_eq("s4_f1_x257_y1", cap_data[1157], 32'h0001_0101);
      check_eq("s4_tlast_299", cap_last[299], 1);
      check_eq("s4_tlast_599", cap_last[599], 1);
      check_eq("s4_tuser_600", cap_user[600], 1);
      check_eq("s4_frame_gap", cap_it[600] - cap_it[599], 3);
    end
    @(negedge clk);
    check_eq("s4_done_pulse", frame_done, 1);
    check_eq("s4_frame_count", frame_count, 2);
    @(negedge clk);
    check_eq("s4_stop_a", tvalid, 0);
    @(negedge clk);
    check_eq("s4_stop_b", tvalid, 0);

    // Checker 20x2, enable dropped and width/pattern changed after beat 4
    set_cfg(12'd20, 12'd2, 2'd3, 24'hABCDEF);
    enable = 1'b1;
    clear_cap();
    capture("s5a", 5, 1'b0, 20);
    enable      = 1'b0;
    cfg_width   = 12'd4;
    cfg_pattern = 2'd0;
    capture("s5b", 35, 1'b0, 60);
    for (int i = 0; i < 40; i++) begin
      if (i < cap_data.size()) begin
        // F=2: x+2 has bit 4 set for x=14..19; y stays below 16.
        check_eq($sformatf("s5_beat%0d", i),
                 {cap_user[i], cap_last[i], cap_data[i]},
                 {(i == 0), ((i % 20) == 19),
                  ((i % 20) >= 14) ? 32'h00AB_CDEF : 32'h0000_0000});
      end
    end
    @(negedge clk);
    check_eq("s5_done_pulse", {frame_done, tvalid}, 2'b10);
    check_eq("s5_frame_count", frame_count, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("s5_idle%0d", i), tvalid, 0);
    end

    // Gradient 4x2, asynchronous reset while beat 4 is presented
    set_cfg(12'd4, 12'd2, 2'd1, 24'h000000);
    enable = 1'b1;
    clear_cap();
    capture("s6a", 5, 1'b0, 20);
    #1 aresetn = 1'b0;
    #1;
    check_eq("s6_async_outputs",
             {tdata, tvalid, tlast, tuser, frame_done, frame_count},
             0);
    @(negedge clk);
    aresetn = 1'b1;
    clear_cap();
    capture("s6b", 1, 1'b0, 10);
    enable = 1'b0;
    capture("s6c", 7, 1'b0, 20);
    if (cap_data.size() == 8) begin
      check_eq("s6_first_latency", cap_it[0], 1);
      check_eq("s6_first_beat", {cap_user[0], cap_last[0], cap_data[0]}, {2'b10, 32'h0});
      check_eq("s6_beat1", cap_data[1], 32'h0000_0001);
      check_eq("s6_beat4", {cap_user[4], cap_data[4]}, {1'b0, 32'h0000_0100});
      check_eq("s6_tlast3", cap_last[3], 1);
    end
    @(negedge clk);
    check_eq("s6_frame_count", frame_count, 1);

    // Zero width/height clamp to a single 1x1 beat
    set_cfg(12'd0, 12'd0, 2'd0, 24'h010203);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    clear_cap();
    capture("s7a", 1, 1'b0, 10);
    if (cap_data.size() == 1)
      check_eq("s7_single_beat", {cap_user[0], cap_last[0], cap_data[0]}, {2'b11, 32'h0001_0203});
    @(negedge clk);
    check_eq("s7_done_pulse", {frame_done, tvalid}, 2'b10);
    check_eq("s7_frame_count", frame_count, 2);

    // Oversized width clamps to 1280
    set_cfg(12'd4095, 12'd1, 2'd1, 24'h000000);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    clear_cap();
    capture("s7b", 1280, 1'b0, 1400);
    if (cap_data.size() == 1280) begin
      check_eq("s7_tlast_1278", cap_last[1278], 0);
      check_eq("s7_tlast_1279", cap_last[1279], 1);
      check_eq("s7_pixel_1279", cap_data[1279], 32'h0002_00FF);
    end
    @(negedge clk);
    check_eq("s7_clamp_done", {frame_done, tvalid}, 2'b10);
    check_eq("s7_clamp_count", frame_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/video_pattern_source.md
# video_pattern_source

AXI4-Stream video source for bring-up and self-test. It generates 32-bit-per-pixel frames with start-of-frame (`tuser`) and end-of-line (`tlast`) markers. The output can drive the video formatter's `m_axis_vid_*` input in place of the VDMA, so the DVI path can be checked without framebuffer traffic. Frame geometry and pattern are latched at every frame start, and the block fully honours `tready` backpressure.

## Interface
- `MAXWIDTH`, 1280: upper clamp for latched width.
- `MAXHEIGHT`, 1024: upper clamp for latched height.

- `m_axis_vid_aclk`  in  1  clock; the only clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `m_axis_vid_tdata`  out  32  pixel `{8'h00, B, G, R}`, one pixel per beat.
- `m_axis_vid_tvalid`  out  1  beat valid.
- `m_axis_vid_tready`  in  1  sink ready.
- `m_axis_vid_tlast`  out  1  last pixel of line.
- `m_axis_vid_tuser`  out  1  first pixel of frame (x=0, y=0).
- `enable`  in  1  level; while high, frames are produced back-to-back.
- `cfg_width`  in  12  pixels per line; latched in LOAD.
- `cfg_height`  in  12  lines per frame; latched in LOAD.
- `cfg_pattern`  in  2  pattern select: 0 solid, 1 gradient, 2 bars, 3 checker. Latched in LOAD.
- `cfg_color`  in  24  `{B, G, R}` colour for solid and checker; latched in LOAD.
- `frame_count`  out  16  completed frames; wraps at 16 bits.
- `frame_done`  out  1  one-cycle pulse after the last beat of a frame.

## Operation
- **States:**
  - IDLE: `tvalid`=0. If `enable`=1, go to LOAD.
  - LOAD: one cycle. Latch the cfg inputs, clear x and y, go to STREAM.
  - STREAM: present beats.
  - DONE: one cycle. `frame_done`=1 and `frame_count`+1. Go to LOAD if `enable`=1, else IDLE.
- **Clamping:** latched width and height below 1 become 1; above `MAXWIDTH`/`MAXHEIGHT` they clamp to the maximum.
- **Beat markers:** `tuser`=1 exactly when x=0 and y=0. `tlast`=1 exactly when x=width-1.
- **Counter advance:** on handshake (`tvalid` && `tready`), x increments.
  - At x=width-1: x←0 and y increments.
  - At x=width-1 and y=height-1 (last beat): go to DONE.
- **Patterns:** x, y are 12-bit beat coordinates; F = `frame_count[7:0]` latched at LOAD.
  - 0 solid: `{B,G,R}` = `cfg_color`.
  - 1 gradient: R=x[7:0], G=y[7:0], B=F.
  - 2 bars: c = ~x[9:7]. R = c[1]?FF:00, G = c[2]?FF:00, B = c[0]?FF:00. Bars every 128 px, in order white, yellow, cyan, green, magenta, red, blue, black.
  - 3 checker: s = (x + {4'b0, F}) mod 4096. Output `cfg_color` when s[4]^y[4]=1, else 0. The pattern scrolls 1 px per frame.
- **Mid-frame cfg changes:** ignored until the next LOAD.
- **Dropping `enable` mid-frame:** the current frame always completes; it is never truncated, because the sink relies on `tuser`/`tlast`. IDLE follows DONE.
- **Reset (asynchronous, including mid-frame):**
  - All outputs go to 0, `frame_count`=0, state IDLE.
  - After reset the next frame starts with a `tuser` beat.

## Timing
- **Reset values:** `tdata`=0, `tvalid`=0, `tlast`=0, `tuser`=0, `frame_done`=0, `frame_count`=0.
- **Registered outputs:** all outputs come from registers; there is no combinational path from `tready` to any output.
- **Handshake:** once `tvalid` rises it stays high, and `tdata`/`tlast`/`tuser` stay stable, until a handshake occurs. The next beat is presented on the cycle after the handshake.
- **Throughput:** one beat per cycle while `tready`=1. `tvalid` never drops inside a frame.
- **Start latency:** `enable` rising in IDLE gives LOAD on the next edge, and the first beat with `tvalid`=1 one cycle later.
- **Frame gap:** two `tvalid`=0 cycles (DONE, LOAD) between the last beat and the next `tuser` beat.
- **Frame-done timing:** `frame_done` asserts the cycle after the final handshake. `frame_count` updates on the same edge.
- **Arithmetic widths:** x and y compare at 12 bits. The checker sum wraps mod 4096. `frame_count` wraps 0xFFFF→0.

## Test plan
- **Solid frame, no backpressure.** Width 4, height 2, pattern 0, `cfg_color`=0x332211, `tready`=1, `enable` pulsed for one frame.
  - 8 beats of 0x00332211.
  - `tuser` on beat 0 only; `tlast` on beats 3 and 7.
  - `frame_done` one cycle later; `frame_count`=1.
- **Backpressure.** Same frame with `tready` random at 50%.
  - `tdata`/`tuser`/`tlast` held during every stall.
  - Exactly 8 handshakes, same sequence as the first scenario.
- **Colour bars.** Width 1024, height 1, pattern 2. Required beat values:
  - x=0 → 0x00FFFFFF
  - x=128 → 0x0000FFFF
  - x=640 → 0x000000FF
  - x=1023 → 0x00000000
- **Gradient over consecutive frames.** Width 300, height 2, pattern 1, `enable` held high.
  - Frame 0, x=257, y=1 → 0x00000101.
  - Frame 1, same pixel → 0x00010101.
  - Exactly 2 idle cycles between frames.
- **Mid-frame enable and cfg changes.** Drop `enable` and change `cfg_width` mid-frame.
  - The frame completes with the old width.
  - DONE, then `tvalid` stays 0.
- **Reset mid-frame.** Assert `aresetn`=0 at beat 5.
  - All outputs are 0 within the same cycle.
  - On release with `enable`=1, the first beat is `tuser`=1, x=0.
